// File: rtl/keypad_debounce_encoder.sv
// Keypad front end: 2-flop sync, priority encode, debounce FSM, one-shot KEY_VALID.
// Optional auto-repeat while a key is held is compiled in with `define KEY_REPEAT_EN.
module keypad_debounce_encoder #(
  parameter int unsigned DEB_CYCLES    = 4,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned REPEAT_DELAY  = 16,
  parameter int unsigned REPEAT_PERIOD = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_0,
  input  logic       BTN1,
  input  logic       BTN2,
  input  logic       BTN3,
  input  logic       BTN4,
  input  logic       BTN5,
  input  logic       BTN6,
  input  logic       BTN7,
  input  logic       BTN8,
  input  logic       BTN9,
  input  logic       BTN_star,
  input  logic       BTN_sharp,
  output logic [3:0] KEY_CODE,
  output logic       KEY_VALID,
  output logic       KEY_HELD
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] DEB_TERM = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if (DEB_CYCLES < 1 || DEB_CYCLES > 255 || CNT_W < 1 || CNT_W > 16 ||
        DEB_CYCLES > (1 << CNT_W) || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
        REPEAT_DELAY > (1 << CNT_W) || REPEAT_PERIOD > (1 << CNT_W)) begin : g_bad_cfg
      $error("keypad_debounce_encoder: illegal parameter combination");
    end
  endgenerate

  // Bit index equals the key code, so the encoder output needs no lookup table.
  logic [11:0] btn_raw;
  assign btn_raw = {BTN_sharp, BTN_star, BTN9, BTN8, BTN7, BTN6,
                    BTN5, BTN4, BTN3, BTN2, BTN1, BTN_0};

  logic [11:0]      sync1_q, s_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       cap_q, cap_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       cand;
  logic             any_press, s_cap, accept, rpt_fire;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q     <= '0;
      s_q         <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cap_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      sync1_q     <= btn_raw;
      s_q         <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  // Lowest index wins: scanning downward lets the last hit overwrite.
  always_comb begin
    cand = 4'd0;
    for (int i = 11; i >= 0; i--) begin
      if (s_q[i]) cand = 4'(i);
    end
  end

  assign any_press = |s_q;
  assign s_cap     = s_q[cap_q];
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_press) begin
          cap_d   = cand;
          cnt_d   = '0;
          state_d = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (!s_cap) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_q == DEB_TERM) begin
            state_d = ST_HELD;
            accept  = 1'b1;
          end
        end
      end
      ST_HELD: begin
        if (!s_cap) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // A high sample here is contact bounce on release, never a new press.
        if (s_cap) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_TERM) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DELAY_TERM  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_PERIOD_TERM = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_arm_q, rpt_arm_d;

  // rpt_arm_q selects the initial delay versus the steady repeat period.
  always_comb begin
    rpt_fire  = 1'b0;
    rpt_cnt_d = '0;
    rpt_arm_d = 1'b0;
    if (state_q == ST_HELD && s_cap) begin
      if (rpt_arm_q ? (rpt_cnt_q == RPT_PERIOD_TERM) : (rpt_cnt_q == RPT_DELAY_TERM)) begin
        rpt_fire  = 1'b1;
        rpt_arm_d = 1'b1;
      end else begin
        rpt_cnt_d = (rpt_cnt_q == CNT_MAX) ? rpt_cnt_q : rpt_cnt_q + CNT_ONE;
        rpt_arm_d = rpt_arm_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rpt_cnt_q <= '0;
      rpt_arm_q <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      rpt_arm_q <= rpt_arm_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_comb begin
    key_valid_d = accept | rpt_fire;
    key_code_d  = accept ? cap_q : key_code_q;
    KEY_HELD    = (state_q == ST_HELD) || (state_q == ST_RELEASE);
  end

  assign KEY_CODE  = key_code_q;
  assign KEY_VALID = key_valid_q;

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Directed bench for keypad_debounce_encoder: every KEY_VALID pulse is matched
// against a queue of {edge number, key code} entries pushed when a press is driven.
module tb_keypad_debounce_encoder;

  localparam int DEB = 4;
  localparam int RD  = 16;
  localparam int RP  = 8;
  localparam int W   = 20;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [11:0] btn = '0;
  logic [3:0]  KEY_CODE;
  logic        KEY_VALID;
  logic        KEY_HELD;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [W-1:0] exp_q[$];

  keypad_debounce_encoder #(
    .DEB_CYCLES(DEB), .CNT_W(8), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLK(CLK), .RST(RST),
    .BTN_0(btn[0]), .BTN1(btn[1]), .BTN2(btn[2]), .BTN3(btn[3]),
    .BTN4(btn[4]), .BTN5(btn[5]), .BTN6(btn[6]), .BTN7(btn[7]),
    .BTN8(btn[8]), .BTN9(btn[9]), .BTN_star(btn[10]), .BTN_sharp(btn[11]),
    .KEY_CODE(KEY_CODE), .KEY_VALID(KEY_VALID), .KEY_HELD(KEY_HELD)
  );

  // Clock / edge counter: at the negedge after rising edge N, cyc == N.
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push_exp(input int edge_n, input logic [3:0] code);
    logic [15:0] e16;
    e16 = edge_n[15:0];
    exp_q.push_back({e16, code});
  endtask

  // Scoreboard: each observed pulse must be the oldest expected one, on its edge.
  always @(negedge CLK) begin
    if (RST && KEY_VALID) begin
      logic [W-1:0] e;
      logic [15:0]  c16;
      c16 = cyc[15:0];
      if (exp_q.size() == 0) e = '1;
      else e = exp_q.pop_front();
      check("key_valid_event", {c16, KEY_CODE}, e);
    end
  end

  initial begin
    int c0;
    // Reset with BTN1 already pressed.
    RST = 1'b0;
    btn[1] = 1'b1;
    tick(4);
    check("reset_valid", W'(KEY_VALID), W'(0));
    check("reset_held", W'(KEY_HELD), W'(0));
    check("reset_code", W'(KEY_CODE), W'(0));

    // BTN1 becomes a fresh press once reset is released.
    RST = 1'b1;
    push_exp(cyc + DEB + 3, 4'd1);
    tick(3);
    check("held_before_accept", W'(KEY_HELD), W'(0));
    tick(14);
    check("held_while_pressed", W'(KEY_HELD), W'(1));
    check("code_btn1", W'(KEY_CODE), W'(1));
    btn[1] = 1'b0;
    tick(6);
    check("held_during_release_debounce", W'(KEY_HELD), W'(1));
    tick(1);
    check("held_cleared_after_release", W'(KEY_HELD), W'(0));
    check("code_kept_after_release", W'(KEY_CODE), W'(1));
    tick(3);

    // Bounce on press, then a one-cycle glitch while held.
    btn[7] = 1'b1; tick(2);
    btn[7] = 1'b0; tick(1);
    btn[7] = 1'b1;
    push_exp(cyc + DEB + 3, 4'd7);
    tick(12);
    check("held_btn7", W'(KEY_HELD), W'(1));
    check("code_btn7", W'(KEY_CODE), W'(7));
    btn[7] = 1'b0; tick(1);
    btn[7] = 1'b1; tick(8);
    check("held_through_glitch", W'(KEY_HELD), W'(1));
    btn[7] = 1'b0; tick(10);
    check("released_btn7", W'(KEY_HELD), W'(0));

    // Priority: '#' and '0' together, then '*' and '#' alone.
    btn[11] = 1'b1; btn[0] = 1'b1;
    push_exp(cyc + DEB + 3, 4'd0);
    tick(10);
    check("code_priority_0_over_sharp", W'(KEY_CODE), W'(0));
    btn[11] = 1'b0; btn[0] = 1'b0; tick(10);
    btn[10] = 1'b1;
    push_exp(cyc + DEB + 3, 4'hA);
    tick(10);
    check("code_star", W'(KEY_CODE), W'(4'hA));
    btn[10] = 1'b0; tick(10);
    btn[11] = 1'b1;
    push_exp(cyc + DEB + 3, 4'hB);
    tick(10);
    check("code_sharp", W'(KEY_CODE), W'(4'hB));
    btn[11] = 1'b0; tick(10);
    check("released_sharp", W'(KEY_HELD), W'(0));

    // Short glitch shorter than the debounce window.
    btn[5] = 1'b1; tick(2);
    btn[5] = 1'b0; tick(10);
    check("glitch_code_unchanged", W'(KEY_CODE), W'(4'hB));
    check("glitch_not_held", W'(KEY_HELD), W'(0));

    // Long hold: one event, plus auto-repeats when the feature is built in.
    btn[0] = 1'b1;
    c0 = cyc;
    push_exp(c0 + DEB + 3, 4'd0);
`ifdef KEY_REPEAT_EN
    for (int k = 0; k < 5; k++) push_exp(c0 + DEB + 3 + RD + k * RP, 4'd0);
`endif
    tick(60);
    btn[0] = 1'b0; tick(10);
    check("long_hold_released", W'(KEY_HELD), W'(0));
    check("long_hold_code", W'(KEY_CODE), W'(0));

    // Still-pressed lower-priority key is re-evaluated after release.
    btn[2] = 1'b1; btn[3] = 1'b1;
    push_exp(cyc + DEB + 3, 4'd2);
    tick(10);
    check("code_btn2_wins", W'(KEY_CODE), W'(2));
    btn[2] = 1'b0;
    push_exp(cyc + 12, 4'd3);
    tick(16);
    check("code_btn3_reevaluated", W'(KEY_CODE), W'(3));
    check("held_btn3", W'(KEY_HELD), W'(1));
    btn[3] = 1'b0; tick(10);

    // Asynchronous reset while debouncing.
    btn[9] = 1'b1; tick(5);
    #2 RST = 1'b0;
    #1;
    check("async_rst_debounce_code", W'(KEY_CODE), W'(0));
    check("async_rst_debounce_valid", W'(KEY_VALID), W'(0));
    btn[9] = 1'b0; tick(3);
    RST = 1'b1; tick(12);
    check("after_rst_debounce_held", W'(KEY_HELD), W'(0));

    // Asynchronous reset while held.
    btn[9] = 1'b1;
    push_exp(cyc + DEB + 3, 4'd9);
    tick(9);
    check("code_btn9", W'(KEY_CODE), W'(9));
    check("held_btn9", W'(KEY_HELD), W'(1));
    #2 RST = 1'b0;
    #1;
    check("async_rst_held_held", W'(KEY_HELD), W'(0));
    check("async_rst_held_code", W'(KEY_CODE), W'(0));
    btn[9] = 1'b0; tick(3);
    RST = 1'b1; tick(10);
    check("after_rst_held_held", W'(KEY_HELD), W'(0));
    check("after_rst_held_code", W'(KEY_CODE), W'(0));

    tick(5);
    check("scoreboard_drained", W'(exp_q.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
